fifo_mem_sched: RTL and testbench
=================================

// Module: fifo_mem_sched
// PURPOSE
//  Sequences one single-port synchronous RAM (2**AW x DW) as a FIFO between a producer and a consumer.
//  Holds 13-bit wrap-bit write/read pointers and arbitrates the single RAM port between write and read
//  grants. Drives a 2-entry output buffer so the consumer sees valid/ready streaming data.
//  Sits between the capture datapath and the downstream consumer; owns the RAM port exclusively.
// PARAMETERS
//  DW  8   data width
//  AW  12  RAM address width; DEPTH = 2**AW = 4096 entries
// PORTS
//  clk        in   1     single clock, all logic on posedge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     producer has data
//  in_data    in   DW    producer data
//  in_ready   out  1     write granted this cycle; transfer when in_valid && in_ready
//  out_valid  out  1     output buffer head valid
//  out_data   out  DW    output buffer head
//  out_ready  in   1     consumer accepts; pop when out_valid && out_ready
//  mem_en     out  1     RAM access this cycle
//  mem_we     out  1     1 = write, 0 = read
//  mem_addr   out  AW    w_ptr[AW-1:0] on write, r_ptr[AW-1:0] on read
//  mem_wdata  out  DW    = in_data (combinational)
//  mem_rdata  in   DW    RAM read data, valid the cycle after a read
//  full       out  1     RAM holds DEPTH entries: ptrs differ, low AW bits equal
//  level      out  AW+1  RAM entries + reads in flight + output-buffer entries, 0..DEPTH+2
// BEHAVIOUR
//  - Reset (async, rst_n=0): w_ptr=r_ptr=0, buffer empty, rd_pend=0, last_grant=RD.
//    Outputs: in_ready=0, out_valid=0, out_data=0, mem_en=0, mem_we=0, full=0, level=0.
//    Reset mid-transfer drops any in-flight read and all buffered data. Nothing is held over.
//  - Requests:
//    wr_req = in_valid && !full
//    rd_req = (w_ptr != r_ptr) && (buf_cnt + rd_pend - pop) < 2
//  - Grant (combinational, one per cycle):
//    only wr_req -> WR; only rd_req -> RD; both -> opposite of last_grant; neither -> idle (mem_en=0).
//    last_grant updates only when a grant is issued.
//  - WR grant: in_ready=1, mem_en=1, mem_we=1. On the clock edge w_ptr += 1 (13-bit, wraps naturally).
//  - RD grant: mem_en=1, mem_we=0. On the clock edge r_ptr += 1 and rd_pend=1.
//    On the next edge mem_rdata is pushed into the buffer and rd_pend clears, unless a new read is issued.
//  - Read latency: RAM read issue to out_valid is 2 cycles when the buffer is empty.
//  - Buffer: 2-entry FIFO. Push and pop in the same cycle are both honoured. Never overflows, because rd_req accounts for rd_pend.
//  - full is a combinational compare of the pointers. in_ready is never 1 while full.
//    Reads keep draining the RAM while full.
//  - Throughput: write-only = 1/cycle. Both streaming = alternating WR/RD, 0.5/cycle each.
//  - Address wrap: entry 4096 goes to addr 0 with pointer bit 12 toggled. No special case.
// STRUCTURE
//  - fifo_sched_pkg: AW/DW defaults, DEPTH, grant enum {GR_NONE, GR_WR, GR_RD}.
//  - Sub-module out_buf2: 2-entry valid/ready buffer with push, pop, count, head.
//  - The top holds the pointers, arbiter, rd_pend and level arithmetic.
// TESTING
//  1 rst_n pulsed low mid-stream (async, between edges) -> all outputs 0 immediately;
//    after release, first write lands at mem_addr=0.
//  2 out_ready=0, in_valid=1 continuous -> exactly 4098 transfers accepted (4096 RAM + 2 buffer);
//    then full=1, in_ready=0, level=4098.
//  3 From test 2, out_ready=1 -> data pops in order 0,1,2...; full drops after the first RAM read;
//    all 4098 values are correct.
//  4 in_valid=1 and out_ready=1, steady state with RAM non-empty -> mem_we alternates 1,0,1,0;
//    in_ready high every other cycle.
//  5 Write 1 word into an empty FIFO, out_ready=1 -> RAM read issued 1 cycle after the write;
//    out_valid 2 cycles after the read; level returns to 0 after the pop.
//  6 Wrap: push/pop 5000 words, random valid/ready -> ordering correct across addr 4095->0;
//    pointer bit 12 toggles; never mem_en with conflicting we.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared sizes, grant encoding and the single-port arbitration rule
// for the RAM-backed FIFO scheduler.
package fifo_sched_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 12;
   localparam int DEPTH  = 2 ** AW_DEF;

   typedef enum logic [1:0] {
      GR_NONE = 2'd0,
      GR_WR   = 2'd1,
      GR_RD   = 2'd2
   } grant_e;

   // Contention alternates: a tie goes to whoever did not win last time.
   function automatic grant_e arb_pick(input logic wr_req, input logic rd_req, input logic last_rd);
      grant_e g;
      case ({wr_req, rd_req})
         2'b10:   g = GR_WR;
         2'b01:   g = GR_RD;
         2'b11:   g = last_rd ? GR_WR : GR_RD;
         default: g = GR_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/out_buf2.sv
// Two-entry valid/ready buffer holding RAM read data in front of the consumer.
module out_buf2 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [1:0]    o_count,
   output logic          o_valid,
   output logic [DW-1:0] o_head
);

   logic [DW-1:0] r_mem [2];
   logic          r_wr_idx;
   logic          r_rd_idx;
   logic [1:0]    r_cnt;
   logic          w_push;
   logic          w_pop;

   // A push into a full buffer is only taken when a pop frees the slot.
   assign w_pop  = i_pop && (r_cnt != 2'd0);
   assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

   // Storage, ring indices and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= {DW{1'b0}};
         r_mem[1] <= {DW{1'b0}};
         r_wr_idx <= 1'b0;
         r_rd_idx <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_idx] <= i_data;
            r_wr_idx        <= ~r_wr_idx;
         end
         if (w_pop) begin
            r_rd_idx <= ~r_rd_idx;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_count = r_cnt;
   assign o_valid = (r_cnt != 2'd0);
   assign o_head  = r_mem[r_rd_idx];

endmodule

// File: rtl/fifo_mem_sched.sv
// Runs one single-port RAM as a FIFO: wrap-bit pointers, a WR/RD arbiter for
// the shared port, and a 2-entry output buffer fed by reads in flight.
module fifo_mem_sched
   import fifo_sched_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          full,
   output logic [AW:0]   level
);

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        r_rd_pend;
   logic        r_last_rd;
   logic        r_active;
   logic [1:0]  w_buf_cnt;
   logic        w_pop;
   logic        w_wr_req;
   logic        w_rd_req;
   logic [2:0]  w_occ;
   logic [AW:0] w_ram_cnt;
   grant_e      w_grant;

   assign full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop = out_valid && out_ready;

   // Buffer slots already claimed once this cycle's pop is honoured.
   assign w_occ = {1'b0, w_buf_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};

   // r_active keeps the port idle for the first edge after reset so no
   // grant can appear while rst_n is still low.
   assign w_wr_req = r_active && in_valid && !full;
   assign w_rd_req = r_active && (r_wptr != r_rptr) && (w_occ < 3'd2);

   assign mem_wdata = in_data;
   assign w_ram_cnt = r_wptr - r_rptr;
   assign level     = w_ram_cnt + {{AW{1'b0}}, r_rd_pend} + {{(AW-1){1'b0}}, w_buf_cnt};

   // Grant decode and RAM port drive.
   always_comb begin
      w_grant  = arb_pick(w_wr_req, w_rd_req, r_last_rd);
      in_ready = 1'b0;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = r_rptr[AW-1:0];
      case (w_grant)
         GR_WR: begin
            in_ready = 1'b1;
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = r_wptr[AW-1:0];
         end
         GR_RD: begin
            mem_en   = 1'b1;
            mem_addr = r_rptr[AW-1:0];
         end
         default: begin
            mem_en = 1'b0;
         end
      endcase
   end

   // Pointers, read-in-flight flag and arbitration history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= {(AW+1){1'b0}};
         r_rptr    <= {(AW+1){1'b0}};
         r_rd_pend <= 1'b0;
         r_last_rd <= 1'b1;
         r_active  <= 1'b0;
      end else begin
         r_active  <= 1'b1;
         r_rd_pend <= (w_grant == GR_RD);
         if (w_grant == GR_WR) begin
            r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_grant == GR_RD) begin
            r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_grant != GR_NONE) begin
            r_last_rd <= (w_grant == GR_RD);
         end
      end
   end

   out_buf2 #(.DW(DW)) u_out_buf2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_rd_pend),
      .i_data  (mem_rdata),
      .i_pop   (w_pop),
      .o_count (w_buf_cnt),
      .o_valid (out_valid),
      .o_head  (out_data)
   );

endmodule

// File: tb/tb_fifo_mem_sched.sv
// Bench for fifo_mem_sched: external RAM model, a queue-based reference of the
// FIFO contents, a directed cycle table and multi-cycle corner sequences.
module tb_fifo_mem_sched;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        full;
   logic [12:0] level;

   fifo_mem_sched dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .full(full), .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] ram [4096];
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      else if (mem_en) mem_rdata <= ram[mem_addr];
   end

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [7:0] ref_q [$];
   int wr_cnt = 0;
   int rd_cnt = 0;
   int pop_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: the FIFO is the ordered list of accepted words not yet popped.
   always @(negedge clk) begin
      logic [7:0] exp_d;
      if (mon_en) begin
         chk("level", 32'(level), 32'(ref_q.size()));
         chk("full", 32'(full), 32'((wr_cnt - rd_cnt) == 4096));
         chk("ir_vs_we", 32'(in_ready), 32'(mem_en && mem_we));
         chk("ir_while_full", 32'(in_ready && full), 32'd0);
         if (in_valid && in_ready) begin
            chk("wr_addr", 32'(mem_addr), 32'(wr_cnt % 4096));
            ref_q.push_back(in_data);
            wr_cnt++;
         end
         if (mem_en && !mem_we) begin
            chk("rd_addr", 32'(mem_addr), 32'(rd_cnt % 4096));
            rd_cnt++;
         end
         if (out_valid && out_ready) begin
            if (ref_q.size() == 0) begin
               chk("pop_on_empty", 32'd1, 32'd0);
            end else begin
               exp_d = ref_q.pop_front();
               chk("out_data", 32'(out_data), 32'(exp_d));
            end
            pop_cnt++;
         end
      end
   end

   typedef struct {
      logic        iv;
      logic [7:0]  id;
      logic        ordy;
      logic        e_ir;
      logic        e_en;
      logic        e_we;
      logic [11:0] e_addr;
      logic        e_ov;
      logic [7:0]  e_od;
      logic [12:0] e_lvl;
   } vec_t;

   vec_t vt [15];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int n;
      tick;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (level != 13'd0 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(level), 32'd0);
   endtask

   initial begin
      int start;
      int pstart;
      int n;
      logic prev_we;

      vt[0]  = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 8'h00, 13'd0};
      vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 8'h00, 13'd1};
      vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 8'h00, 13'd1};
      vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 8'hA1, 13'd1};
      vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 8'h00, 13'd0};
      vt[5]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 12'd1, 1'b0, 8'h00, 13'd0};
      vt[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1, 1'b0, 8'h00, 13'd1};
      vt[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 12'd2, 1'b0, 8'h00, 13'd1};
      vt[8]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 12'd2, 1'b1, 8'h10, 13'd2};
      vt[9]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 12'd3, 1'b1, 8'h10, 13'd2};
      vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 8'h10, 13'd3};
      vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'd3, 1'b1, 8'h10, 13'd3};
      vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 8'h11, 13'd2};
      vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 8'h12, 13'd1};
      vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 8'h00, 13'd0};

      // Reset state, with the producer already asserting valid.
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      #9;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Directed cycle table: single-word latency, contention, buffer fill/drain.
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         in_valid = vt[i].iv; in_data = vt[i].id; out_ready = vt[i].ordy;
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
         chk($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(vt[i].e_en));
         chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
         chk($sformatf("tbl%0d_level", i), 32'(level), 32'(vt[i].e_lvl));
         chk($sformatf("tbl%0d_full", i), 32'(full), 32'd0);
         if (vt[i].e_en) chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
         if (vt[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(vt[i].e_od));
      end

      // Asynchronous reset in the middle of a stream.
      tick;
      in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b0;
      repeat (6) tick;
      @(negedge clk);
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      tick;
      mon_en = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
      chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
      chk("mid_rst_full", 32'(full), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      ref_q.delete();
      wr_cnt = 0; rd_cnt = 0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      mon_en = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 5) begin
         @(negedge clk);
         n++;
      end
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_addr", 32'(mem_addr), 32'd0);
      drain("drain_after_rst");

      // Fill with the consumer stalled: RAM plus both buffer slots.
      start = wr_cnt;
      tick;
      in_valid = 1'b1; out_ready = 1'b0; in_data = 8'(wr_cnt - start);
      repeat (4300) begin
         tick;
         in_data = 8'(wr_cnt - start);
      end
      @(negedge clk);
      chk("fill_count", 32'(wr_cnt - start), 32'd4098);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_level", 32'(level), 32'd4098);

      // Release the consumer: first cycle reads the RAM, which clears full.
      tick;
      in_valid = 1'b0; out_ready = 1'b1;
      pstart = pop_cnt;
      @(negedge clk);
      chk("unfill_rd_en", 32'(mem_en), 32'd1);
      chk("unfill_rd_we", 32'(mem_we), 32'd0);
      chk("unfill_full_before", 32'(full), 32'd1);
      tick;
      @(negedge clk);
      chk("unfill_full_after", 32'(full), 32'd0);
      drain("unfill_drain");
      chk("unfill_pops", 32'(pop_cnt - pstart), 32'd4098);

      // Producer and consumer both streaming with data in the RAM.
      tick;
      in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
      repeat (10) tick;
      out_ready = 1'b1;
      repeat (10) tick;
      @(negedge clk);
      prev_we = mem_we;
      for (int i = 0; i < 20; i++) begin
         tick;
         @(negedge clk);
         chk("alt_mem_en", 32'(mem_en), 32'd1);
         chk("alt_mem_we", 32'(mem_we), 32'(!prev_we));
         chk("alt_in_ready", 32'(in_ready), 32'(!prev_we));
         prev_we = mem_we;
      end
      drain("alt_drain");

      // Random traffic across the address wrap.
      start = wr_cnt;
      n = 0;
      while ((wr_cnt - start) < 5000 && n < 40000) begin
         tick;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         n++;
      end
      chk("rand_written", 32'((wr_cnt - start) >= 5000), 32'd1);
      drain("rand_drain");
      chk("rand_all_read", 32'(rd_cnt), 32'(wr_cnt));
      chk("rand_wrapped", 32'(rd_cnt > 4096), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
